// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR state encoding, default tap masks and next-state function
package lfsr_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } dec_state_t;

  // Maximal-length XNOR tap masks, bit i set means state bit i feeds back.
  function automatic logic [31:0] lfsr_default_taps(input int len);
    case (len)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Fibonacci XNOR step; identical to the versatile counter so both walk the same sequence.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps,
                                            input int len);
    logic [31:0] mask;
    logic        fb;
    mask = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    fb   = ~^(s & taps & mask);
    return ((s << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - combinational one-step LFSR next-state of width LENGTH
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int              LENGTH = 8,
  parameter logic [LENGTH-1:0] TAPS = LENGTH'(lfsr_default_taps(LENGTH))
) (
  input  logic [LENGTH-1:0] s,
  output logic [LENGTH-1:0] nxt
);

  // Advance the state by one LFSR step using the shared polynomial.
  always_comb begin
    nxt = LENGTH'(lfsr_next(32'(s), 32'(TAPS), LENGTH));
  end

endmodule

// File: rtl/lfsr_decoder.sv
// rtl/lfsr_decoder.sv - LFSR code to binary index decoder; LFSR_DECODER_ABORT_EN adds an abort input
module lfsr_decoder
  import lfsr_pkg::*;
#(
  parameter int                LENGTH = 8,
  parameter logic [LENGTH-1:0] TAPS   = LENGTH'(lfsr_default_taps(LENGTH)),
  parameter logic [LENGTH-1:0] SEED   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cke,
  input  logic              start,
`ifdef LFSR_DECODER_ABORT_EN
  input  logic              abort,
`endif
  input  logic [LENGTH-1:0] lfsr_in,
  output logic              busy,
  output logic              done,
  output logic [LENGTH-1:0] index,
  output logic              err
);

  // The walker visits every sequence state within this many steps; beyond it the code is the lockup state.
  localparam logic [LENGTH-1:0] CNT_LIMIT = {{(LENGTH-1){1'b1}}, 1'b0};

  dec_state_t        state;
  dec_state_t        state_nxt;
  logic [LENGTH-1:0] capt;
  logic [LENGTH-1:0] walker;
  logic [LENGTH-1:0] walker_nxt;
  logic [LENGTH-1:0] cnt;
  logic              match;
  logic              at_limit;
  logic              abort_hit;

`ifdef LFSR_DECODER_ABORT_EN
  assign abort_hit = abort && (state == SEARCH);
`else
  assign abort_hit = 1'b0;
`endif

  assign match    = (walker == capt);
  assign at_limit = (cnt == CNT_LIMIT);

  lfsr_step #(
    .LENGTH (LENGTH),
    .TAPS   (TAPS)
  ) u_walker_step (
    .s   (walker),
    .nxt (walker_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: start leaves IDLE without cke; a search ends on abort, or on match/limit with cke.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (abort_hit) begin
          state_nxt = IDLE;
        end else if (cke && (match || at_limit)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state == SEARCH);
  end

  // Search datapath: capture on accept, walk on enabled edges, latch the result with a one-cycle done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      capt   <= '0;
      walker <= '0;
      cnt    <= '0;
      index  <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            capt   <= lfsr_in;
            walker <= SEED;
            cnt    <= '0;
          end
        end
        SEARCH: begin
          if (!abort_hit && cke) begin
            if (match) begin
              index <= cnt;
              err   <= 1'b0;
              done  <= 1'b1;
            end else if (at_limit) begin
              index <= '1;
              err   <= 1'b1;
              done  <= 1'b1;
            end else begin
              walker <= walker_nxt;
              cnt    <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decoder.sv
// tb/tb_lfsr_decoder.sv - randomized self-checking bench for lfsr_decoder against a sequence-table model
module tb_lfsr_decoder;

  localparam logic [7:0] TB_TAPS = 8'hB8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cke = 1'b1;
  logic       start = 1'b0;
  logic [7:0] lfsr_in = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] index;
  logic       err;
`ifdef LFSR_DECODER_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] cur_code = 8'h00;
  int pos [logic [7:0]];
  logic [7:0] seq [0:254];

  lfsr_decoder #(
    .LENGTH (8),
    .TAPS   (TB_TAPS),
    .SEED   (8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cke     (cke),
    .start   (start),
`ifdef LFSR_DECODER_ABORT_EN
    .abort   (abort),
`endif
    .lfsr_in (lfsr_in),
    .busy    (busy),
    .done    (done),
    .index   (index),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (code %02h): got %0h expected %0h", tag, cur_code, got, exp);
    end
  endtask

  // Reference sequence: shift left, new bit is 1 when an even number of tapped bits are set.
  function automatic logic [7:0] ref_step(input logic [7:0] s);
    int   ones;
    logic fb;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (s[i] && TB_TAPS[i]) ones++;
    end
    fb = ((ones % 2) == 0);
    return {s[6:0], fb};
  endfunction

  task automatic build_model();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 255; i++) begin
      pos[s] = i;
      seq[i] = s;
      s = ref_step(s);
    end
  endtask

  task automatic decode(input logic [7:0] code, input int stall_at, input int stall_len,
                        input bit rnd_cke, input bit poke);
    int exp_idx;
    bit exp_err;
    int exp_act;
    int exp_lat;
    int lat;
    int act;
    int busy_n;
    bit overlap;
    bit done_stall;
    bit seen;
    cur_code = code;
    if (pos.exists(code)) begin
      exp_idx = pos[code];
      exp_err = 1'b0;
      exp_act = exp_idx + 1;
    end else begin
      exp_idx = 255;
      exp_err = 1'b1;
      exp_act = 255;
    end
    exp_lat = exp_act + ((stall_at >= 0 && stall_at < exp_act) ? stall_len : 0);
    @(negedge clk);
    start   = 1'b1;
    lfsr_in = code;
    @(negedge clk);
    start   = 1'b0;
    lfsr_in = 8'($urandom);
    lat = 0; act = 0; busy_n = 0; overlap = 0; done_stall = 0; seen = 0;
    while (!seen && lat < 1200) begin
      if (busy) busy_n++;
      if (rnd_cke) cke = ($urandom_range(0, 3) != 0);
      else cke = !(stall_at >= 0 && lat >= stall_at && lat < stall_at + stall_len);
      start   = poke && (lat == 1 || lat == 3 || lat == exp_lat - 1);
      lfsr_in = 8'($urandom);
      @(negedge clk);
      lat++;
      if (cke) act++;
      if (busy && done) overlap = 1'b1;
      if (done && !cke) done_stall = 1'b1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    cke   = 1'b1;
    check("done_seen", 32'(seen), 32'd1);
    check("active_edges", act, exp_act);
    if (!rnd_cke) begin
      check("latency", lat, exp_lat);
      check("busy_cycles", busy_n, exp_lat);
    end
    check("index", 32'(index), exp_idx);
    check("err", 32'(err), 32'(exp_err));
    check("busy_done_overlap", 32'(overlap), 32'd0);
    check("done_while_cke_low", 32'(done_stall), 32'd0);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("no_restart", 32'(busy), 32'd0);
    check("index_held", 32'(index), exp_idx);
  endtask

  initial begin
    build_model();
    #3 rst = 1'b0;
    #20;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_index", 32'(index), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    decode(8'h00, -1, 0, 1'b0, 1'b0);
    check("dir_00_idx", 32'(index), 32'd0);
    decode(8'h1E, -1, 0, 1'b0, 1'b0);
    check("dir_1E_idx", 32'(index), 32'd5);
    decode(8'h0F, -1, 0, 1'b0, 1'b0);
    check("dir_0F_idx", 32'(index), 32'd4);
    decode(8'hFF, -1, 0, 1'b0, 1'b0);
    check("dir_FF_idx", 32'(index), 32'hFF);
    check("dir_FF_err", 32'(err), 32'd1);
    decode(8'h03, -1, 0, 1'b0, 1'b0);
    check("dir_03_idx", 32'(index), 32'd2);
    check("dir_03_err", 32'(err), 32'd0);

    decode(8'h1E, 2, 10, 1'b0, 1'b1);
    check("stall_1E_idx", 32'(index), 32'd5);

    for (int i = 0; i < 255; i++) begin
      decode(seq[i], -1, 0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      decode(8'($urandom_range(0, 255)), -1, 0, 1'b1, (i % 2) == 1);
    end
    decode(8'hFF, -1, 0, 1'b1, 1'b0);

    decode(8'h03, -1, 0, 1'b0, 1'b0);
    cur_code = 8'hFF;
    @(negedge clk);
    start   = 1'b1;
    lfsr_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_index", 32'(index), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_rst_busy", 32'(busy), 32'd0);

`ifdef LFSR_DECODER_ABORT_EN
    begin
      bit seen_done;
      decode(8'h0F, -1, 0, 1'b0, 1'b0);
      cur_code = 8'h1E;
      @(negedge clk);
      start   = 1'b1;
      lfsr_in = 8'h1E;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      abort = 1'b1;
      cke   = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      abort = 1'b0;
      cke   = 1'b1;
      seen_done = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (done) seen_done = 1'b1;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      check("abort_index_kept", 32'(index), 32'd4);
      check("abort_err_kept", 32'(err), 32'd0);
      cur_code = 8'h03;
      abort   = 1'b1;
      start   = 1'b1;
      lfsr_in = 8'h03;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check("abort_start_accept", 32'(busy), 32'd1);
      seen_done = 1'b0;
      for (int k = 0; k < 20 && !seen_done; k++) begin
        @(negedge clk);
        if (done) seen_done = 1'b1;
      end
      check("abort_start_done", 32'(seen_done), 32'd1);
      check("abort_start_idx", 32'(index), 32'd2);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
